// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder sequencer.
//   cla_state_e : controller state encoding (IDLE / RUN / DONE)
//   NIB_W       : width of the shared lookahead slice in bits
//   width_ok()  : elaboration-time legality check for the WIDTH parameter
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cla_state_e;

    // WIDTH must be a whole, non-zero number of slices.
    function automatic bit width_ok(input int w);
        return (w >= NIB_W) && ((w % NIB_W) == 0);
    endfunction

endpackage

// File: rtl/cla_seq_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_ctrl.
//   in_valid/in_ready, in_a, in_b, in_cin : operand request channel
//   out_valid/out_ready, out_sum, out_cout : result channel
//   busy                                   : controller status
// slave modport is the controller side; master modport is the source/sink side.
interface cla_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/cla_nibble.sv
// Purely combinational 4-bit carry-lookahead adder slice.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum
//   cout : carry out of bit 3
module cla_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p and cin, so no carry
    // depends on a lower carry through a ripple chain.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/cla_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared cla_nibble slice processes one
// nibble per clock, LSB first, with the inter-nibble carry held in a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cla_seq_ctrl_if.slave (operand request, result, busy)
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    cla_seq_ctrl_if.slave       bus
);
    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    if (!width_ok(WIDTH)) begin : g_width_chk
        $error("cla_seq_ctrl: WIDTH must be a non-zero multiple of 4");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // Bit offset of the current nibble: idx * 4.
    logic [IDX_W+1:0] bit_base;
    logic [3:0]       sl_a, sl_b, sl_s;
    logic             sl_cout;

    assign bit_base = {idx_q, 2'b00};
    assign sl_a     = a_q[bit_base +: NIB_W];
    assign sl_b     = b_q[bit_base +: NIB_W];

    cla_nibble u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[bit_base +: NIB_W] = sl_s;
                carry_d = sl_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = sl_cout;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // in_ready is gated by rst_n so the source never sees a ready during reset.
    assign bus.in_ready  = rst_n && (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
module tb_cla_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cla_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: an operation in flight, cycles elapsed since acceptance,
    // its arithmetic result, and the last result delivered to the sink.
    logic             m_busy = 1'b0;
    int               m_cnt  = 0;
    logic [WIDTH:0]   m_res  = '0;
    logic [WIDTH:0]   m_last = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
            m_last <= '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_res  <= {1'b0, bus.in_a} + {1'b0, bus.in_b} + (WIDTH+1)'(bus.in_cin);
            end
        end else if (m_cnt < NIB) begin
            m_cnt <= m_cnt + 1;
        end else if (bus.out_ready) begin
            m_busy <= 1'b0;
            m_last <= m_res;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, rst_n && !m_busy);
            chk("busy", bus.busy, m_busy);
            chk("out_valid", bus.out_valid, m_busy && (m_cnt == NIB));
            if (m_busy && (m_cnt == NIB)) begin
                chk("done_sum", bus.out_sum, m_res[WIDTH-1:0]);
                chk("done_cout", bus.out_cout, m_res[WIDTH]);
            end else if (!m_busy) begin
                chk("idle_sum", bus.out_sum, m_last[WIDTH-1:0]);
                chk("idle_cout", bus.out_cout, m_last[WIDTH]);
            end
        end
    end

    // Present operands and hold them until the controller takes them.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int w;
        w = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = WIDTH'($urandom);
        bus.in_b     = WIDTH'($urandom);
        bus.in_cin   = 1'($urandom);
    endtask

    // Called right after acceptance: check latency and the delivered result.
    task automatic wait_done(input logic [WIDTH-1:0] es, input logic ec);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(NIB));
        chk("sum", bus.out_sum, es);
        chk("cout", bus.out_cout, ec);
    endtask

    task automatic release_result(input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        logic [WIDTH:0]   rr;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 64'd0);
        chk("rst_out_valid", bus.out_valid, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 64'd1);
        chk("post_rst_out_valid", bus.out_valid, 64'd0);
        chk("post_rst_sum", bus.out_sum, 64'h0000);
        chk("post_rst_cout", bus.out_cout, 64'd0);
        chk("post_rst_busy", bus.busy, 64'd0);
        @(posedge clk); #1;

        accept(16'h0001, 16'h0000, 1'b0);
        wait_done(16'h0001, 1'b0);
        release_result(0);

        accept(16'hFFFF, 16'h0001, 1'b0);
        wait_done(16'h0000, 1'b1);
        release_result(1);

        accept(16'hFFFF, 16'h0000, 1'b1);
        wait_done(16'h0000, 1'b1);
        release_result(0);

        accept(16'h0BF9, 16'h0609, 1'b1);
        wait_done(16'h1203, 1'b0);
        release_result(0);

        // Backpressure: hold the result while a new request is offered.
        accept(16'h1234, 16'h4321, 1'b0);
        wait_done(16'h5555, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                bus.in_valid = 1'b1;
                bus.in_a     = 16'hAAAA;
                bus.in_b     = 16'h0F0F;
                bus.in_cin   = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("bp_valid", bus.out_valid, 64'd1);
            chk("bp_sum", bus.out_sum, 64'h5555);
            chk("bp_in_ready", bus.in_ready, 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_valid", bus.out_valid, 64'd0);
        chk("bp_release_ready", bus.in_ready, 64'd1);
        accept(16'h00FF, 16'h0F01, 1'b0);
        wait_done(16'h1000, 1'b0);
        release_result(0);

        // Reset in the middle of RUN with a carry-in that would contaminate.
        accept(16'h1234, 16'h1111, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 64'd0);
        chk("mid_rst_sum", bus.out_sum, 64'h0000);
        chk("mid_rst_cout", bus.out_cout, 64'd0);
        chk("mid_rst_busy", bus.busy, 64'd0);
        chk("mid_rst_in_ready", bus.in_ready, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        accept(16'h1234, 16'h1111, 1'b0);
        wait_done(16'h2345, 1'b0);
        release_result(0);

        // Randomized operations with random sink stalls and idle gaps.
        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            if (n % 8 == 0) ra = '1;
            rr = {1'b0, ra} + {1'b0, rb} + (WIDTH+1)'(rc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            accept(ra, rb, rc);
            wait_done(rr[WIDTH-1:0], rr[WIDTH]);
            release_result(int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
